// File: rtl/aes_dfa_sequencer.sv
`timescale 1ns/1ps
// aes_dfa_sequencer
//   Drives an aes_128 fault-injection core for differential fault analysis.
//   Each request sends the same plaintext/key into the core twice on
//   consecutive cycles: first fault-free, then faulted. It pulses fault_en
//   once, when the second block sits at the round-9 stage, captures both
//   ciphertexts, and hands them downstream as a valid/ready pair.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request pulse, accepted only when idle
//   pt, key_in      plaintext / key, latched on the accepting edge
//   bit_sel         state bit to flip in the faulted block
//   busy            high whenever a request is in progress
//   aes_state/key   block inputs to the core (zero when not issuing)
//   aes_fault_en    single-cycle fault strobe to the core
//   aes_fault_bit   bit index to the core (valid while busy)
//   aes_out         core ciphertext output
//   ct_good         fault-free ciphertext
//   ct_faulty       faulted ciphertext
//   pair_valid      ct_good/ct_faulty valid
//   pair_ready      consumer accepts the pair
//
// LATENCY is assumed to be at least 2, and S9_DELAY must be less than LATENCY.
module aes_dfa_sequencer #(
  parameter int LATENCY  = 20,
  parameter int S9_DELAY = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] pt,
  input  logic [127:0] key_in,
  input  logic [6:0]   bit_sel,
  output logic         busy,
  output logic [127:0] aes_state,
  output logic [127:0] aes_key,
  output logic         aes_fault_en,
  output logic [6:0]   aes_fault_bit,
  input  logic [127:0] aes_out,
  output logic [127:0] ct_good,
  output logic [127:0] ct_faulty,
  output logic         pair_valid,
  input  logic         pair_ready
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  // cnt equals k during cycle k, where edge 0 is the edge on which the core
  // samples the good block.
  localparam logic [CNT_W-1:0] CNT_GOOD  = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_FAULT = CNT_W'(S9_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_GOOD,
    ISSUE_FAULT,
    WAIT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     pt_r;
  logic [127:0]     key_r;
  logic [6:0]       bit_r;

  // The counter saturates at the faulty-capture cycle and does not wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // All outputs are decoded from registered state/cnt. This keeps the
  // fault strobe free of glitches relative to the core's sampling edge.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    aes_state     = '0;
    aes_key       = '0;
    aes_fault_en  = 1'b0;
    aes_fault_bit = '0;
    pair_valid    = 1'b0;

    unique case (state)
      IDLE:        if (start) state_next = ISSUE_GOOD;
      ISSUE_GOOD:  state_next = ISSUE_FAULT;
      ISSUE_FAULT: state_next = WAIT;
      WAIT:        if (cnt == CNT_MAX) state_next = HOLD;
      HOLD:        if (pair_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase

    if (state != IDLE) begin
      busy          = 1'b1;
      aes_fault_bit = bit_r;
    end

    if (state == ISSUE_GOOD || state == ISSUE_FAULT) begin
      aes_state = pt_r;
      aes_key   = key_r;
    end

    // The faulted block entered the core at edge 1. It therefore reaches
    // round 9 one cycle after the good block does.
    if ((state == ISSUE_FAULT || state == WAIT) && cnt == CNT_FAULT) begin
      aes_fault_en = 1'b1;
    end

    if (state == HOLD) begin
      pair_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pt_r      <= '0;
      key_r     <= '0;
      bit_r     <= '0;
      ct_good   <= '0;
      ct_faulty <= '0;
    end else begin
      if (state == IDLE && start) begin
        pt_r  <= pt;
        key_r <= key_in;
        bit_r <= bit_sel;
      end

      unique case (state)
        ISSUE_GOOD:        cnt <= '0;
        ISSUE_FAULT, WAIT: cnt <= sat_inc(cnt);
        default:           cnt <= cnt;
      endcase

      // Captures are keyed only to this run's cnt. Stale blocks still
      // inside the reset-less core are never sampled.
      if (state == WAIT && cnt == CNT_GOOD) begin
        ct_good <= aes_out;
      end
      if (state == WAIT && cnt == CNT_MAX) begin
        ct_faulty <= aes_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_dfa_sequencer.sv
`timescale 1ns/1ps
// Bench for aes_dfa_sequencer. It includes a behavioural, reset-less
// aes_128 pipeline that injects a bit flip into the round-9 input state
// when fault_en is high.
module tb_aes_dfa_sequencer;

  localparam int LAT = 20;
  localparam int S9  = 18;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] pt = '0;
  logic [127:0] key_in = '0;
  logic [6:0]   bit_sel = '0;
  logic         pair_ready = 1'b1;
  logic         busy;
  logic [127:0] aes_state;
  logic [127:0] aes_key;
  logic         aes_fault_en;
  logic [6:0]   aes_fault_bit;
  logic [127:0] aes_out;
  logic [127:0] ct_good;
  logic [127:0] ct_faulty;
  logic         pair_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] g;
    logic [127:0] f;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  aes_dfa_sequencer #(.LATENCY(LAT), .S9_DELAY(S9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pt           (pt),
    .key_in       (key_in),
    .bit_sel      (bit_sel),
    .busy         (busy),
    .aes_state    (aes_state),
    .aes_key      (aes_key),
    .aes_fault_en (aes_fault_en),
    .aes_fault_bit(aes_fault_bit),
    .aes_out      (aes_out),
    .ct_good      (ct_good),
    .ct_faulty    (ct_faulty),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready)
  );

  // ---------------- reference AES ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // A fault flips bit fb of the 128-bit state entering round 9.
  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k,
                                           input logic flt, input logic [6:0] fb);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] t0, rcon, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    rcon = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        t0     = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rcon;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[t0];
        rcon   = xtime(rcon);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      if (r == 9 && flt) s[15 - int'(fb) / 8] ^= 8'(1 << (int'(fb) % 8));
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Bit i is set when byte i (byte 0 = MSB) of a and b differ.
  function automatic logic [15:0] diff_mask(input logic [127:0] a, input logic [127:0] b);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = (a[127-8*i -: 8] != b[127-8*i -: 8]);
    return m;
  endfunction

  // Round-9 ShiftRows moves the faulted byte into column j. MixColumns
  // spreads it over that column, and round-10 ShiftRows scatters the result.
  function automatic logic [15:0] expect_mask(input logic [6:0] b);
    int bi, r, c, j, col;
    logic [15:0] m;
    m  = '0;
    bi = 15 - int'(b) / 8;
    r  = bi % 4;
    c  = bi / 4;
    j  = (c + 4 - r) % 4;
    for (int rr = 0; rr < 4; rr++) begin
      col = (j + 4 - rr) % 4;
      m[4*col+rr] = 1'b1;
    end
    return m;
  endfunction

  // ---------------- core model (no reset, like the real core) ----------------
  logic [127:0] pipe_ct  [LAT+1];
  logic [127:0] pipe_pt  [LAT+1];
  logic [127:0] pipe_key [LAT+1];

  assign aes_out = pipe_ct[LAT];

  always @(posedge clk) begin
    pipe_pt[0]  <= aes_state;
    pipe_key[0] <= aes_key;
    pipe_ct[0]  <= aes_enc(aes_state, aes_key, 1'b0, 7'd0);
    for (int i = 1; i <= LAT; i++) begin
      pipe_pt[i]  <= pipe_pt[i-1];
      pipe_key[i] <= pipe_key[i-1];
      if (aes_fault_en && (i - 1) == S9)
        pipe_ct[i] <= aes_enc(pipe_pt[i-1], pipe_key[i-1], 1'b1, aes_fault_bit);
      else
        pipe_ct[i] <= pipe_ct[i-1];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete request. With bp=0, pair_ready stays 1. Otherwise the pair
  // is backpressured for bp HOLD cycles while start pulses are driven.
  task automatic do_run(input logic [127:0] p, input logic [127:0] k, input logic [6:0] b,
                        input int bp, input logic is_fips);
    int pulses, pulse_at, pv_at;
    exp_t e;
    logic [127:0] g_at, f_at;
    pulses = 0; pulse_at = -99; pv_at = -1;
    pair_ready = (bp == 0);
    @(negedge clk);
    chk("idle_before_start", 128'(busy), 128'd0);
    pt = p; key_in = k; bit_sel = b; start = 1'b1;
    exp_q.push_back('{g: aes_enc(p, k, 1'b0, 7'd0), f: aes_enc(p, k, 1'b1, b)});
    @(posedge clk);
    #1;
    start = 1'b0; pt = ~p; key_in = ~k; bit_sel = ~b;
    for (int cyc = -1; cyc <= LAT + 8; cyc++) begin
      @(negedge clk);
      if (aes_fault_en) begin pulses++; pulse_at = cyc; end
      if (cyc == -1) begin
        chk("issue_good_state", aes_state, p);
        chk("issue_good_key", aes_key, k);
      end
      if (cyc == 0) chk("issue_fault_state", aes_state, p);
      if (cyc == 1) chk("wait_state_zero", aes_state | aes_key, 128'd0);
      if (cyc == S9 + 1) chk("fault_bit", 128'(aes_fault_bit), 128'(b));
      if (pair_valid) begin pv_at = cyc; break; end
    end
    chk("pv_cycle", 128'(pv_at), 128'(LAT + 2));
    chk("fault_pulses", 128'(pulses), 128'd1);
    chk("fault_cycle", 128'(pulse_at), 128'(S9 + 1));
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 128'd0, 128'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ct_good", ct_good, e.g);
      chk("ct_faulty", ct_faulty, e.f);
    end
    chk("diff_mask", 128'(diff_mask(ct_good, ct_faulty)), 128'(expect_mask(b)));
    if (is_fips) chk("fips_ct_good", ct_good, FIPS_CT);
    g_at = ct_good; f_at = ct_faulty;
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        start = (i % 2 == 0);
        pt = 128'(i);
        chk("bp_valid_busy", 128'({pair_valid, busy}), 128'b11);
        chk("bp_ct_good", ct_good, g_at);
        chk("bp_ct_faulty", ct_faulty, f_at);
      end
      @(negedge clk);
      start = 1'b0;
      pair_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("idle_after_hs", 128'({busy, pair_valid}), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, v;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      v = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = v;
    end

    // Reset state with junk on the inputs.
    #1 rst_n = 1'b0;
    pt = {4{32'hdeadbeef}}; key_in = {4{32'hcafef00d}}; bit_sel = 7'h55;
    #12;
    chk("rst_ctl", 128'({busy, aes_fault_en, pair_valid, aes_fault_bit}), 128'd0);
    chk("rst_data", aes_state | aes_key | ct_good | ct_faulty, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 128'(busy), 128'd0);

    // FIPS-197 vector: fault at bit 0, then at bit 127.
    do_run(FIPS_PT, FIPS_KEY, 7'd0, 0, 1'b1);
    do_run(FIPS_PT, FIPS_KEY, 7'h7f, 0, 1'b1);

    // Backpressure for 10 cycles, with start pulses while busy.
    do_run(FIPS_PT, FIPS_KEY, 7'd33, 10, 1'b1);
    @(negedge clk);
    chk("no_queued_start", 128'(busy), 128'd0);

    // Reset during WAIT at cnt=10.
    @(negedge clk);
    pt = FIPS_PT; key_in = FIPS_KEY; bit_sel = 7'd40; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chk("mid_busy", 128'({busy, aes_fault_en}), 128'b10);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 128'({busy, aes_fault_en, pair_valid, aes_fault_bit}), 128'd0);
    chk("midrst_data", aes_state | aes_key | ct_good | ct_faulty, 128'd0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (aes_fault_en) pulses++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("midrst_no_pulse", 128'(pulses), 128'd0);
    do_run(FIPS_PT, FIPS_KEY, 7'd5, 0, 1'b1);

    // Back-to-back random runs.
    for (int n = 0; n < 16; n++) begin
      do_run({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             7'($urandom_range(0, 127)), 0, 1'b0);
    end

    // Fault bit sweep on the fixed vector.
    for (int b = 0; b < 128; b++) begin
      do_run(FIPS_PT, FIPS_KEY, 7'(b), 0, 1'b1);
    end

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
